// File: rtl/dpram_req_adapter.sv
// dpram_req_adapter: command FIFO -> dpram port handshake -> latency pipe -> response FIFO.
// Define DPRAM_ADAPTER_WRITE_RSP_EN to make writes consume credit and return an acknowledgement.
module dpram_req_adapter #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 6,
    parameter int CMD_DEPTH  = 4,
    parameter int RSP_DEPTH  = 2,
    parameter int RD_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_we,
    input  logic [ADDR_W-1:0]           cmd_addr,
    input  logic [DATA_W-1:0]           cmd_wdata,
    output logic                        mem_valid,
    input  logic                        mem_ready,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_data,
    input  logic [DATA_W-1:0]           mem_q,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic [ADDR_W-1:0]           rsp_addr,
    output logic                        busy,
    output logic [$clog2(CMD_DEPTH):0]  cmd_count
`ifdef DPRAM_ADAPTER_WRITE_RSP_EN
    ,
    output logic                        rsp_is_write
`endif
);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = RSP_DEPTH > 1 ? $clog2(RSP_DEPTH) : 1;
    localparam int RCW = $clog2(RSP_DEPTH + 1);
`ifdef DPRAM_ADAPTER_WRITE_RSP_EN
    localparam bit WRESP = 1'b1;
`else
    localparam bit WRESP = 1'b0;
`endif
    typedef enum logic {IDLE, REQ} state_t;
    state_t state;
    logic [CAW-1:0] c_wr, c_rd, c_rd_n;
    logic [CAW:0] c_cnt, c_left, c_cnt_n;
    logic c_we [CMD_DEPTH];
    logic [ADDR_W-1:0] c_addr [CMD_DEPTH];
    logic [DATA_W-1:0] c_data [CMD_DEPTH];
    logic [RCW-1:0] credit, credit_n, r_cnt;
    logic [RD_LATENCY-1:0] p_v;
    logic [ADDR_W-1:0] p_addr [RD_LATENCY];
    logic [RAW-1:0] r_wr, r_rd;
    logic [ADDR_W-1:0] r_addr [RSP_DEPTH];
    logic [DATA_W-1:0] r_data [RSP_DEPTH];
    logic [DATA_W-1:0] exit_data;
    logic push, pop, issue, rsp_push, rsp_pop, head_we_n, elig_n;

    assign cmd_ready = c_cnt < (CAW+1)'(CMD_DEPTH);
    assign cmd_count = c_cnt;
    assign push      = cmd_valid && cmd_ready;
    assign mem_valid = state == REQ;
    assign pop       = mem_valid && mem_ready;
    assign issue     = pop && (!c_we[c_rd] || WRESP);
    assign mem_we    = mem_valid && c_we[c_rd];
    assign mem_addr  = mem_valid ? c_addr[c_rd] : '0;
    assign mem_data  = mem_valid ? c_data[c_rd] : '0;
    assign rsp_valid = r_cnt != '0;
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign rsp_push  = p_v[RD_LATENCY-1];
    assign rsp_rdata = rsp_valid ? r_data[r_rd] : '0;
    assign rsp_addr  = rsp_valid ? r_addr[r_rd] : '0;
    assign busy      = c_cnt != '0 || |p_v || rsp_valid || mem_valid;

    // Eligibility is evaluated on next-cycle FIFO/credit values so issue is back-to-back.
    assign c_left    = c_cnt - (CAW+1)'(pop);
    assign c_cnt_n   = c_left + (CAW+1)'(push);
    assign c_rd_n    = c_rd + CAW'(pop);
    assign head_we_n = c_left == '0 ? cmd_we : c_we[c_rd_n];
    assign credit_n  = credit - RCW'(issue) + RCW'(rsp_pop);
    assign elig_n    = c_cnt_n != '0 && (credit_n != '0 || (head_we_n && !WRESP));

`ifdef DPRAM_ADAPTER_WRITE_RSP_EN
    logic [RD_LATENCY-1:0] p_w;
    logic r_w [RSP_DEPTH];
    assign exit_data    = p_w[RD_LATENCY-1] ? '0 : mem_q;
    assign rsp_is_write = rsp_valid && r_w[r_rd];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) p_w <= '0;
        else p_w <= (p_w << 1) | RD_LATENCY'(issue && c_we[c_rd]);
    end
    always_ff @(posedge clk) begin
        if (rsp_push) r_w[r_wr] <= p_w[RD_LATENCY-1];
    end
`else
    assign exit_data = mem_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            c_wr   <= '0;
            c_rd   <= '0;
            c_cnt  <= '0;
            credit <= RCW'(RSP_DEPTH);
            p_v    <= '0;
            r_wr   <= '0;
            r_rd   <= '0;
            r_cnt  <= '0;
        end else begin
            state  <= elig_n ? REQ : IDLE;
            c_wr   <= c_wr + CAW'(push);
            c_rd   <= c_rd_n;
            c_cnt  <= c_cnt_n;
            credit <= credit_n;
            p_v    <= (p_v << 1) | RD_LATENCY'(issue);
            if (rsp_push) r_wr <= r_wr == RAW'(RSP_DEPTH - 1) ? '0 : r_wr + RAW'(1);
            if (rsp_pop) r_rd <= r_rd == RAW'(RSP_DEPTH - 1) ? '0 : r_rd + RAW'(1);
            r_cnt  <= r_cnt + RCW'(rsp_push) - RCW'(rsp_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            c_we[c_wr]   <= cmd_we;
            c_addr[c_wr] <= cmd_addr;
            c_data[c_wr] <= cmd_wdata;
        end
        p_addr[0] <= c_addr[c_rd];
        for (int i = 1; i < RD_LATENCY; i++) p_addr[i] <= p_addr[i-1];
        if (rsp_push) begin
            r_addr[r_wr] <= p_addr[RD_LATENCY-1];
            r_data[r_wr] <= exit_data;
        end
    end
endmodule

// File: doc/dpram_req_adapter.md
Name: dpram_req_adapter

Overview:
Upstream request adapter that feeds one port of the dual-port RAM (dpram). It accepts a command stream (valid/ready), buffers it in a small FIFO, and drives the dpram port's valid/ready handshake. It captures read data from q after a fixed latency and returns it on a response stream with backpressure. One instance sits in front of each of port A and port B.

Parameters:
DATA_W, 8, data width; matches dpram data_a/data_b and q_a/q_b.
ADDR_W, 6, address width; matches dpram addr_a/addr_b.
CMD_DEPTH, 4, command FIFO entries; must be a power of 2 and at least 2.
RSP_DEPTH, 2, response FIFO entries; must be at least 1.
RD_LATENCY, 1, cycles from an accepted read handshake to q being valid; must be at least 1.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst_n  in  1  asynchronous active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  command FIFO not full.
cmd_we  in  1  1 = write, 0 = read.
cmd_addr  in  ADDR_W  command address.
cmd_wdata  in  DATA_W  write data; ignored for reads.
mem_valid  out  1  to dpram valid_x.
mem_ready  in  1  from dpram ready_x.
mem_we  out  1  to dpram we_x.
mem_addr  out  ADDR_W  to dpram addr_x.
mem_data  out  DATA_W  to dpram data_x.
mem_q  in  DATA_W  from dpram q_x.
rsp_valid  out  1  response present.
rsp_ready  in  1  response consumer ready.
rsp_rdata  out  DATA_W  read data.
rsp_addr  out  ADDR_W  address of the read being returned.
busy  out  1  FIFO non-empty, or reads in flight, or response pending.
cmd_count  out  $clog2(CMD_DEPTH)+1  command FIFO occupancy.

Behaviour:
- Reset, asynchronous, active while rst_n = 0:
  - All outputs go to 0 except cmd_ready, which is 1.
  - Both FIFOs are emptied, the in-flight pipeline is cleared, and the credit counter is set to RSP_DEPTH.
  - Reset during an outstanding read discards that read; no response is produced after release.
- Command accept: a command is accepted when cmd_valid && cmd_ready at a posedge. cmd_ready = (cmd_count < CMD_DEPTH).
- Simultaneous push and pop on a full FIFO: no push, because cmd_ready is 0 when full.
- Simultaneous push and pop otherwise: occupancy is unchanged and order is preserved.
- Issue FSM states:
  - IDLE:
    - If the FIFO is non-empty and the head is a write, go to REQ.
    - If the FIFO is non-empty, the head is a read, and credit > 0, go to REQ.
    - Otherwise stay in IDLE.
  - REQ:
    - mem_valid = 1, with mem_we/mem_addr/mem_data taken from the FIFO head.
    - The handshake completes when mem_valid && mem_ready at a posedge.
    - On the handshake, pop the head. If the popped command was a read, decrement credit and enter the read into the latency pipe.
    - Back-to-back issue: if the next head is eligible, stay in REQ; otherwise go to IDLE.
- Stability rule: while mem_valid = 1 and mem_ready = 0, mem_we, mem_addr and mem_data hold constant and mem_valid stays 1. Withdrawing a request is illegal.
- Latency pipe: an RD_LATENCY-deep shift register of {valid, addr}.
  - When an entry exits, mem_q is sampled on that same edge.
  - The sampled {mem_q, addr} is pushed into the response FIFO.
  - A push can never overflow, guaranteed by credit.
- Response FIFO:
  - rsp_valid = non-empty.
  - A pop happens on rsp_valid && rsp_ready, and each pop increments credit.
  - If a pop and a read issue occur on the same edge, credit is unchanged.
- Credit invariant: credit + in-flight reads + rsp occupancy = RSP_DEPTH, at all times.
- Credit is 0 with a read at the head: the FSM holds in IDLE and issues nothing; a later write is not reordered past it. Strict in-order issue.
- busy = (cmd_count != 0) || in-flight != 0 || rsp_valid || (state == REQ).

Optional Feature:
DPRAM_ADAPTER_WRITE_RSP_EN.
- Defined:
  - Writes also consume a credit and produce a response at the same latency as reads, with rsp_rdata = 0 and rsp_addr = the write address.
  - An extra port, rsp_is_write (out, 1), is 1 for write acknowledgements.
  - Credit gating applies to writes as well.
- Undefined:
  - Writes produce no response and need no credit.
  - The rsp_is_write port is absent.

Test Plan:
- Reset then idle. Checks: cmd_ready = 1, mem_valid = 0, rsp_valid = 0, busy = 0, cmd_count = 0. Then assert rst_n low mid-read; after release, no rsp_valid ever appears.
- Write/read sequence. Stimulus:
  - Write addr 0x05 data 0xA5 with mem_ready tied 1.
  - Read addr 0x05 with RD_LATENCY = 1.
  - Checks: exactly one response, rsp_rdata = 0xA5, rsp_addr = 0x05, arriving 2 cycles after the read is accepted at the command port.
- Backpressure on memory. Stimulus: mem_ready = 0 for 3 cycles during a write to 0x10 data 0x3C. Checks: mem_valid stays 1, mem_addr = 0x10 and mem_data = 0x3C stable all 3 cycles; one handshake only.
- Full command FIFO. Stimulus: mem_ready = 0 and 5 commands pushed. Checks:
  - cmd_count saturates at 4 and cmd_ready goes 0 after the 4th.
  - The 5th command is accepted only after the first mem handshake.
  - Commands emerge in order.
- Credit stall. Stimulus: rsp_ready = 0 and 4 reads issued to 0x00..0x03. Checks:
  - Only 2 mem handshakes occur, then mem_valid stays 0.
  - After rsp_ready = 1, the remaining 2 reads issue.
  - rsp_addr order is 0,1,2,3.
- Write-response macro. With DPRAM_ADAPTER_WRITE_RSP_EN defined, a write to 0x07 gives rsp_valid, rsp_is_write = 1, rsp_addr = 0x07. Without the macro, the same write gives no response.
